adder_arbiter: RTL

- Round-robin controller that shares one combinational 16-bit adder (with carry/parity/overflow/zero/sign flags) among NREQ requesters.
- Each request is accepted over a valid/ready handshake. The arbiter drives the operands to the adder, captures sum and flags in a register, and returns them with the requester ID over a valid/ready response channel.
- Sits between the ALU's client units and the shared adder instance.

---
 rtl/adder_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder among NREQ requesters.
// One transaction in flight: accept, issue to the adder, then hold the response until taken.
module adder_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic [15:0]          add_x,
  output logic [15:0]          add_y,
  input  logic [15:0]          add_z,
  input  logic [4:0]           add_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_z,
  output logic [4:0]           rsp_flags,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  localparam int unsigned CW = IDW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] grant_id_q;
  logic [15:0]    op_x_q;
  logic [15:0]    op_y_q;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] next_ptr;
  logic [CW-1:0]  cand;
  logic [15:0]    sel_x;
  logic [15:0]    sel_y;

  always_comb begin : param_check
    assert (NREQ >= 2 && NREQ <= 8 && IDW == $clog2(NREQ))
      else $fatal(1, "adder_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
  end

  // Search from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = CW'(rr_ptr_q) + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == IDW'(k)) begin
        sel_x = req_x[16*k +: 16];
        sel_y = req_y[16*k +: 16];
      end
    end
  end

  assign next_ptr = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == StIdle && win_found) req_ready[win_idx] = 1'b1;
  end

  assign add_x = op_x_q;
  assign add_y = op_y_q;
  assign busy  = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      op_x_q     <= '0;
      op_y_q     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_z      <= '0;
      rsp_flags  <= '0;
      ops_done   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            op_x_q     <= sel_x;
            op_y_q     <= sel_y;
            grant_id_q <= win_idx;
            rr_ptr_q   <= next_ptr;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          rsp_z     <= add_z;
          rsp_flags <= add_flags;
          rsp_id    <= grant_id_q;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          // Returning to idle here keeps a grant from sharing a cycle with the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
